mux_arb_n: RTL and testbench



---
 rtl/mux_arb_n.sv | 80 ++++++++
 tb/tb_mux_arb_n.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_n.sv
// N-way registered multiplexer with valid/ready handshakes.
// Fixed-select or round-robin arbitration into a single output stage.
module mux_arb_n #(
  parameter int NB_SEL = 2,
  parameter int WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mode,
  input  logic [NB_SEL-1:0]                 sel,
  input  logic [(1<<NB_SEL)-1:0]            in_valid,
  input  logic [(1<<NB_SEL)*WIDTH-1:0]      in_data,
  output logic [(1<<NB_SEL)-1:0]            in_ready,
  output logic                              out_valid,
  output logic [WIDTH-1:0]                  out_data,
  output logic [NB_SEL-1:0]                 out_sel,
  input  logic                              out_ready
);

  localparam int N = 1 << NB_SEL;

  logic [NB_SEL-1:0] ptr;
  logic [NB_SEL-1:0] rr_grant;
  logic [NB_SEL-1:0] idx;
  logic              rr_found;
  logic [NB_SEL-1:0] grant;
  logic              gvalid;
  logic              load;
  logic              take;

  assign load = !out_valid || out_ready;

  // Scan starts one past the last served channel; the add wraps mod N.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = ptr + NB_SEL'(k);
      if (!rr_found && in_valid[idx]) begin
        rr_grant = idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    grant  = sel;
    gvalid = in_valid[sel];
    if (mode) begin
      grant  = rr_grant;
      gvalid = rr_found;
    end
  end

  assign take = load && gvalid && !rst;

  always_comb begin
    in_ready = '0;
    if (take)
      in_ready = N'(1) << grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= NB_SEL'(N - 1);
    end else if (load) begin
      out_valid <= gvalid;
      if (gvalid) begin
        out_data <= in_data[int'(grant)*WIDTH +: WIDTH];
        out_sel  <= grant;
        ptr      <= grant;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n with NB_SEL=2, WIDTH=8.
// Hand-computed expectations checked with immediate assertions.
module tb_mux_arb_n;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int total;
  int bad;

  mux_arb_n #(.NB_SEL(2), .WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .sel(sel),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sel(out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    total = 0;
    bad = 0;
    rst = 1'b1;
    mode = 1'b0;
    sel = 2'd0;
    in_valid = 4'b0000;
    in_data = 32'h0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_sel", 32'(out_sel), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // fixed select
    mode = 1'b0;
    sel = 2'd2;
    in_valid = 4'b1111;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    #1;
    chk("fix_ready", 32'(in_ready), 32'h4);
    tick();
    chk("fix_valid", 32'(out_valid), 32'h1);
    chk("fix_data", 32'(out_data), 32'h33);
    chk("fix_sel", 32'(out_sel), 32'h2);
    sel = 2'd1;
    in_valid = 4'b1101;
    #1;
    chk("fix_noready", 32'(in_ready), 32'h0);
    tick();
    chk("fix_drop", 32'(out_valid), 32'h0);
    chk("fix_hold", 32'(out_data), 32'h33);

    // async reset while holding a beat
    sel = 2'd3;
    in_valid = 4'b1111;
    tick();
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    chk("pre_rst_data", 32'(out_data), 32'h44);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_data", 32'(out_data), 32'h0);
    chk("arst_sel", 32'(out_sel), 32'h0);
    chk("arst_ready", 32'(in_ready), 32'h0);
    tick();
    rst = 1'b0;

    // round-robin fairness, channel 0 first after reset
    mode = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s = i % 4;
      #1;
      chk("rr_ready", 32'(in_ready), 32'(1 << s));
      tick();
      chk("rr_sel", 32'(out_sel), 32'(s));
      chk("rr_data", 32'(out_data), 32'((s + 1) * 17));
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      s = (i % 2 == 0) ? 1 : 3;
      tick();
      chk("rr2_sel", 32'(out_sel), 32'(s));
      chk("rr2_data", 32'(out_data), 32'((s + 1) * 17));
    end

    // backpressure
    mode = 1'b0;
    sel = 2'd3;
    in_valid = 4'b1000;
    in_data = {8'hA5, 8'h33, 8'h22, 8'h11};
    tick();
    chk("bp_load", 32'(out_data), 32'hA5);
    out_ready = 1'b0;
    mode = 1'b1;
    in_valid = 4'b1111;
    in_data = {8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'h0);
      tick();
      chk("bp_data", 32'(out_data), 32'hA5);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_sel", 32'(out_sel), 32'h3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", 32'(in_ready), 32'h1);
    tick();
    chk("bp_next", 32'(out_data), 32'h88);
    chk("bp_next_sel", 32'(out_sel), 32'h0);

    // mode switch
    tick();
    chk("ms_rr1", 32'(out_sel), 32'h1);
    mode = 1'b0;
    sel = 2'd3;
    tick();
    chk("ms_fix1", 32'(out_sel), 32'h3);
    tick();
    chk("ms_fix2", 32'(out_sel), 32'h3);
    chk("ms_fix2_data", 32'(out_data), 32'h55);
    mode = 1'b1;
    #1;
    chk("ms_rr_ready", 32'(in_ready), 32'h1);
    tick();
    chk("ms_rr0", 32'(out_sel), 32'h0);
    chk("ms_rr0_data", 32'(out_data), 32'h88);

    // idle
    in_valid = 4'b0000;
    #1;
    chk("idle_ready", 32'(in_ready), 32'h0);
    tick();
    chk("idle_valid", 32'(out_valid), 32'h0);
    chk("idle_hold", 32'(out_data), 32'h88);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
